// File: rtl/ldst_mem_unit.sv
// MEM-stage load/store engine: aligns and drives one access at a time onto a word-wide req/gnt/rvalid data port.
// Latency: misaligned resp T+1; store resp 1 cycle after gnt; load resp 1 cycle after rvalid (all outputs registered).
// Backpressure: req_ready only in IDLE; memory stalls via mem_gnt/mem_rvalid; response is a one-cycle pulse with no back-pressure.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_ctrl selects LB,LH,LW,LBU,LHU,SB,SH,SW (codes 0..7)
//   req_addr/req_wdata/req_rd     byte address, right-justified store data, destination tag
//   resp_valid/rdata/rd/err       completion pulse, extended load data, echoed tag, 00 ok/01 misaligned/10 timeout
//   mem_req/we/addr/be/wdata      word-aligned memory request, held stable until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata  memory grant, read-data valid and read word
module ldst_mem_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] C_LB  = 3'd0;
  localparam logic [2:0] C_LH  = 3'd1;
  localparam logic [2:0] C_LW  = 3'd2;
  localparam logic [2:0] C_LBU = 3'd3;
  localparam logic [2:0] C_LHU = 3'd4;
  localparam logic [2:0] C_SB  = 3'd5;
  localparam logic [2:0] C_SH  = 3'd6;
  localparam logic [2:0] C_SW  = 3'd7;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q, rdata_d;
  logic [4:0]        resp_rd_q;
  logic [1:0]        resp_err_q, err_d;
  logic              mem_req_q;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Lane steering and alignment check, computed from the incoming request.
  logic [1:0]  in_off;
  logic        in_store;
  logic        in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  always_comb begin
    in_off        = req_addr[1:0];
    in_store      = (req_ctrl >= C_SB);
    in_misaligned = 1'b0;
    in_be         = 4'b1111;
    in_wdata      = '0;
    unique case (req_ctrl)
      C_LH, C_LHU: in_misaligned = in_off[0];
      C_LW:        in_misaligned = (in_off != 2'b00);
      C_SB: begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{req_wdata[7:0]}};
      end
      C_SH: begin
        in_misaligned = in_off[0];
        in_be         = in_off[1] ? 4'b1100 : 4'b0011;
        in_wdata      = {2{req_wdata[15:0]}};
      end
      C_SW: begin
        in_misaligned = (in_off != 2'b00);
        in_wdata      = req_wdata;
      end
      default: ;
    endcase
  end

  // Load extraction from the returned word using the latched offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (ctrl_q)
      C_LB:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      C_LBU:   ld_data = {24'd0, ld_byte};
      C_LH:    ld_data = {{16{ld_half[15]}}, ld_half};
      C_LHU:   ld_data = {16'd0, ld_half};
      C_LW:    ld_data = mem_rdata;
      default: ld_data = '0;
    endcase
  end

  // Next-state logic; response fields are only non-zero on the transition into RESP.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = '0;
    err_d       = ERR_OK;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          ctrl_d      = req_ctrl;
          off_d       = in_off;
          rd_d        = req_rd;
          mem_we_d    = in_store;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = in_be;
          mem_wdata_d = in_wdata;
          if (in_misaligned) begin
            state_d = S_RESP;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = mem_we_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = ld_data;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX)) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Memory-side fields are only meaningful while requesting; keep them quiet otherwise.
    if (state_d != S_REQ) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_be_d    = '0;
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ctrl_q       <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= (state_d == S_RESP);
      resp_rdata_q <= rdata_d;
      resp_rd_q    <= (state_d == S_RESP) ? rd_d : 5'd0;
      resp_err_q   <= err_d;
      mem_req_q    <= (state_d == S_REQ);
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ldst_mem_unit.sv
module tb_ldst_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  ldst_mem_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  err;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] WORD = 32'h80FF7F01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic [4:0] rd, input logic [1:0] err);
    resp_t e;
    e.rdata = rdata;
    e.rd    = rd;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every response pulse pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_rd", 32'(resp_rd), 32'(e.rd));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Called #1 after a rising edge with the unit idle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd);
    req_valid = 1'b1;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 32'h0;
  endtask

  task automatic run_access(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    logic is_load;
    is_load = (ctrl < 3'd5);
    expect_resp(exp_rdata, rd, 2'b00);
    issue(ctrl, addr, wdata, rd);
    for (int i = 0; i <= gnt_dly; i++) begin
      if (i == gnt_dly) mem_gnt = 1'b1;
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("mem_we", 32'(mem_we), 32'(!is_load));
      if (!is_load) chk("mem_wdata", mem_wdata, exp_wdata);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    if (is_load) begin
      for (int i = 0; i < rv_dly; i++) begin
        @(negedge clk);
        chk("wait_no_resp", 32'(resp_valid), 32'd0);
        chk("wait_req_low", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = WORD;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    @(negedge clk);
    chk("resp_latency", 32'(resp_valid), 32'd1);
    chk("mem_req_dropped", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_misaligned(input logic [2:0] ctrl, input logic [31:0] addr, input logic [4:0] rd);
    expect_resp(32'h0, rd, 2'b01);
    issue(ctrl, addr, 32'hFFFF_FFFF, rd);
    @(negedge clk);
    chk("misalign_resp_t1", 32'(resp_valid), 32'd1);
    chk("misalign_no_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("misalign_no_req2", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_ctrl   = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads from word 0x80FF7F01 with varied grant/rvalid stalls.
    run_access(3'd0, 32'h1003, 32'h0, 5'd1, 0, 0, 4'hF, 32'h0, 32'hFFFFFF80); // LB
    run_access(3'd3, 32'h1003, 32'h0, 5'd2, 1, 0, 4'hF, 32'h0, 32'h00000080); // LBU
    run_access(3'd0, 32'h1001, 32'h0, 5'd3, 0, 2, 4'hF, 32'h0, 32'h0000007F); // LB
    run_access(3'd1, 32'h1002, 32'h0, 5'd4, 2, 1, 4'hF, 32'h0, 32'hFFFF80FF); // LH
    run_access(3'd4, 32'h1002, 32'h0, 5'd5, 0, 0, 4'hF, 32'h0, 32'h000080FF); // LHU
    run_access(3'd2, 32'h1000, 32'h0, 5'd6, 1, 1, 4'hF, 32'h0, 32'h80FF7F01); // LW

    // Stores: SH upper half with 3-cycle grant stall, SW full word.
    run_access(3'd6, 32'h2002, 32'h1234ABCD, 5'd10, 3, 0, 4'b1100, 32'hABCDABCD, 32'h0);
    run_access(3'd7, 32'h4000, 32'hDEADBEEF, 5'd11, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);

    // Misaligned accesses never reach memory.
    run_misaligned(3'd2, 32'h1001, 5'd7);   // LW
    run_misaligned(3'd6, 32'h2003, 5'd12);  // SH
    run_misaligned(3'd4, 32'h1001, 5'd13);  // LHU

    // Timeout: granted load, no rvalid; response after 4 WAIT cycles.
    expect_resp(32'h0, 5'd9, 2'b10);
    issue(3'd1, 32'h1002, 32'h0, 5'd9);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("timeout_wait", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("timeout_resp", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = WORD;
    @(negedge clk);
    chk("stray_rvalid_ready", 32'(req_ready), 32'd1);
    chk("stray_rvalid_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid_idle", 32'(req_ready), 32'd1);
    chk("stray_rvalid_no_resp2", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset while waiting for read data: in-flight response is dropped.
    issue(3'd2, 32'h1000, 32'h0, 5'd20);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wait_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait_ready", 32'(req_ready), 32'd1);
    chk("rst_wait_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = WORD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    run_access(3'd5, 32'h3001, 32'h000000AA, 5'd21, 1, 0, 4'b0010, 32'hAAAAAAAA, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against any unbounded run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
